// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-client SDRAM request arbiter.
package mem_arb_pkg;

  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef logic client_id_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; on a tie the client that did not win last goes.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  client_id_t             last,
  output client_id_t             gnt_id,
  output logic                   valid
);

  always_comb begin
    valid  = |req;
    gnt_id = req[1];
    if (&req) gnt_id = ~last;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-client round-robin front end for the SDRAM driver, one transaction in flight.
// Optional watchdog on the completion wait: define MEM_REQ_ARBITER_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for mem_rdy and at least one client request
//   ISSUE | single cycle: r/w strobe to driver, grant pulse to owner
//   WAIT  | strobes low, address/data held, waiting for mem_cplt
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_gnt,
  output logic                  c0_done,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_gnt,
  output logic                  c1_done,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_rdy,
  input  logic                  mem_cplt,
  output logic                  timeout_err
);

  arb_state_t            state;
  client_id_t            owner;
  client_id_t            rr_last;
  client_id_t            pick_id;
  logic                  pick_valid;
  logic                  we_q;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  wd_expire;

  rr_pick2 u_pick (
    .req    ({c1_req, c0_req}),
    .last   (rr_last),
    .gnt_id (pick_id),
    .valid  (pick_valid)
  );

  assign sel_we    = pick_id ? c1_we    : c0_we;
  assign sel_addr  = pick_id ? c1_addr  : c0_addr;
  assign sel_wdata = pick_id ? c1_wdata : c0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
      c0_gnt      <= 1'b0;
      c1_gnt      <= 1'b0;
      c0_done     <= 1'b0;
      c1_done     <= 1'b0;
      c0_rdata    <= '0;
      c1_rdata    <= '0;
    end else begin
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      c0_gnt   <= 1'b0;
      c1_gnt   <= 1'b0;
      c0_done  <= 1'b0;
      c1_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_rdy && pick_valid) begin
            owner       <= pick_id;
            we_q        <= sel_we;
            mem_addr    <= sel_addr;
            mem_data_in <= sel_wdata;
            mem_w_en    <= sel_we;
            mem_r_en    <= ~sel_we;
            c0_gnt      <= (pick_id == 1'b0);
            c1_gnt      <= (pick_id == 1'b1);
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          rr_last <= owner;
          state   <= WAIT;
        end
        WAIT: begin
          // a watchdog expiry completes the transaction but leaves rdata untouched
          if (mem_cplt || wd_expire) begin
            c0_done <= (owner == 1'b0);
            c1_done <= (owner == 1'b1);
            if (mem_cplt && !we_q) begin
              if (owner) c1_rdata <= mem_data_out;
              else       c0_rdata <= mem_data_out;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_expire = (state == WAIT) && !mem_cplt &&
                     (wd_cnt + 16'd1 == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 16'd1;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
